m_seg_scroll_reader: RTL and testbench
======================================

// Module: m_seg_scroll_reader
// PURPOSE
//  Reader side of the 8-bit, 16-entry, active-low 7-segment message ROM.
//  Walks the ROM address space at a slow scroll rate and shifts each fetched glyph into an NDIGIT display buffer.
//  Time-multiplexes that buffer onto a common-cathode/anode board display with active-low digit enables.
//  Sits between the message ROM (combinational adr->dat) and the board seg/an pins.
// PARAMETERS
//  NDIGIT      4         number of multiplexed digits (2..8)
//  SCROLL_DIV  25000000  clk cycles per scroll step (>=4)
//  MUX_DIV     50000     clk cycles per digit slot (>=2)
//  BLANK_CYC   8         blanking cycles per digit switch (only with MUX_BLANK_EN; < MUX_DIV)
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst_n       in   1       asynchronous active-low reset
//  run         in   1       1 = scrolling enabled; 0 = freeze buffer (display keeps refreshing)
//  sel         in   1       message select, forwarded to ROM sw input
//  rom_sw      out  1       registered copy of sel, to ROM
//  rom_adr     out  4       ROM address, registered
//  rom_dat     in   8       ROM glyph {dp,g,f,e,d,c,b,a}, active-low
//  seg         out  8       segment drive, active-low, bit7 = dp
//  an          out  NDIGIT  digit enables, active-low, bit0 = rightmost digit
//  frame_done  out  1       1-cycle pulse when address 4'hf has been loaded
// BEHAVIOUR
//  Reset: rom_adr=0, rom_sw=0, buffer all 8'hFF (blank), seg=8'hFF, an=all 1, frame_done=0, FSM=IDLE, counters=0.
//  Scroll counter: counts 0..SCROLL_DIV-1 only while run=1; cleared when run=0; tick = count==SCROLL_DIV-1.
//  FSM IDLE: on tick -> FETCH.
//  FSM FETCH: one cycle; rom_adr stable, ROM output settles -> LOAD.
//  FSM LOAD: buf[NDIGIT-1:1] <= buf[NDIGIT-2:0]; buf[0] <= rom_dat; rom_adr <= rom_adr+1 (4'hf wraps to 4'h0);
//   frame_done=1 this cycle iff rom_adr was 4'hf; -> IDLE.
//  Latency: glyph visible in buf[0] 2 cycles after tick (tick cycle -> FETCH -> LOAD, registered at end of LOAD).
//  run falls during FETCH/LOAD: step completes; no further ticks until run returns and SCROLL_DIV more cycles elapse.
//  sel change (sel != rom_sw, any state): next cycle rom_sw<=sel, rom_adr<=0, buffer <= all 8'hFF, scroll counter<=0,
//   FSM<=IDLE, frame_done=0; any in-flight step is aborted (no load). Tick in same cycle as sel change is discarded.
//  Mux: slot counter 0..MUX_DIV-1 always running; on wrap digit index advances 0..NDIGIT-1 then back to 0.
//  seg/an registered: an = ~(1<<idx), seg = buf[idx]; one cycle behind index/buffer.
//  Buffer update mid-slot is shown on the next clk (no hold to slot end).
//  Async reset mid-operation: all state returns to reset values immediately; scrolling restarts at adr 0.
// CONFIGURATION
//  MUX_BLANK_EN defined: for the first BLANK_CYC cycles of each digit slot an=all 1 and seg=8'hFF (anti-ghosting);
//   remaining MUX_DIV-BLANK_CYC cycles drive normally.
//  MUX_BLANK_EN undefined: no blanking; an active for the full slot; BLANK_CYC ignored.
// TESTING  (bench params NDIGIT=4, SCROLL_DIV=4, MUX_DIV=2, BLANK_CYC=1, behavioural ROM model)
//  Reset release, run=0, 40 cycles -> rom_adr=0, frame_done never 1, seg=8'hFF in every slot, an cycles E,D,B,7.
//  sel=0, run=1, 4 steps -> buf[3..0]=8'h89,8'h86,8'hC7,8'hC7 (H,E,L,L); rom_adr=4; seg on an=4'hE is 8'hC7.
//  run=1 for 16 steps -> frame_done pulses exactly once, in the LOAD of adr 4'hf; rom_adr wraps to 0.
//  After 5 steps with sel=0, toggle sel to 1 -> next cycle rom_adr=0, buffer all 8'hFF; first step loads 8'hC2 (G).
//  Drop run during FETCH -> load still occurs, rom_adr+1, then no LOAD for >=3*SCROLL_DIV cycles of run=0.
//  Assert rst_n=0 mid-LOAD, release -> all outputs at reset values; with MUX_BLANK_EN, an=4'hF on first cycle of every slot.

Source files
------------

// File: rtl/m_seg_scroll_reader.sv
// m_seg_scroll_reader: scrolls 16 ROM glyphs through an NDIGIT buffer and multiplexes it onto 7-segment digits.
// Define MUX_BLANK_EN to blank the first BLANK_CYC cycles of every digit slot.
module m_seg_scroll_reader #(
    parameter int NDIGIT     = 4,
    parameter int SCROLL_DIV = 25000000,
    parameter int MUX_DIV    = 50000,
    parameter int BLANK_CYC  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              sel,
    output logic              rom_sw,
    output logic [3:0]        rom_adr,
    input  logic [7:0]        rom_dat,
    output logic [7:0]        seg,
    output logic [NDIGIT-1:0] an,
    output logic              frame_done
);
    localparam int SW = $clog2(SCROLL_DIV);
    localparam int MW = $clog2(MUX_DIV);
    localparam int IW = $clog2(NDIGIT);
`ifdef MUX_BLANK_EN
    localparam logic BLANK_ON = 1'b1;
`else
    localparam logic BLANK_ON = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;

    state_t                 state, state_nx;
    logic [SW-1:0]          sc_cnt;
    logic [MW-1:0]          mux_cnt;
    logic [IW-1:0]          idx;
    logic [NDIGIT-1:0][7:0] dbuf;
    logic                   sel_chg, tick, load, mux_wrap, blank;

    assign sel_chg    = sel != rom_sw;
    assign tick       = run && sc_cnt == SW'(SCROLL_DIV - 1);
    assign load       = state == LOAD && !sel_chg;
    assign frame_done = load && rom_adr == 4'hf;
    assign mux_wrap   = mux_cnt == MW'(MUX_DIV - 1);
    assign blank      = BLANK_ON && mux_cnt < MW'(BLANK_CYC);

    always_comb begin
        state_nx = sel_chg         ? IDLE :
                   state == IDLE   ? (tick ? FETCH : IDLE) :
                   state == FETCH  ? LOAD : IDLE;
    end

    // a message switch restarts the scroll from a blank buffer and drops any in-flight step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sc_cnt  <= '0;
            rom_sw  <= 1'b0;
            rom_adr <= 4'h0;
            dbuf    <= '1;
        end else begin
            state  <= state_nx;
            rom_sw <= sel;
            sc_cnt <= (sel_chg || !run || tick) ? '0 : sc_cnt + 1'b1;
            if (sel_chg) begin
                rom_adr <= 4'h0;
                dbuf    <= '1;
            end else if (load) begin
                rom_adr <= rom_adr + 4'h1;
                dbuf    <= {dbuf[NDIGIT-2:0], rom_dat};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_cnt <= '0;
            idx     <= '0;
            seg     <= 8'hFF;
            an      <= '1;
        end else begin
            mux_cnt <= mux_wrap ? '0 : mux_cnt + 1'b1;
            if (mux_wrap)
                idx <= (idx == IW'(NDIGIT - 1)) ? '0 : idx + 1'b1;
            seg <= blank ? 8'hFF : dbuf[idx];
            an  <= blank ? '1 : ~(NDIGIT'(1) << idx);
        end
    end
endmodule

// File: tb/tb_m_seg_scroll_reader.sv
// tb_m_seg_scroll_reader: randomized bench for m_seg_scroll_reader against a glyph-level scroll/display model.
`timescale 1ns/1ps
module tb_m_seg_scroll_reader;
    localparam int NDIGIT     = 4;
    localparam int SCROLL_DIV = 4;
    localparam int MUX_DIV    = 2;
    localparam int BLANK_CYC  = 1;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              run   = 1'b0;
    logic              sel   = 1'b0;
    logic              rom_sw;
    logic [3:0]        rom_adr;
    logic [7:0]        rom_dat;
    logic [7:0]        seg;
    logic [NDIGIT-1:0] an;
    logic              frame_done;

    logic [7:0] rom_tbl [32];
    int compared   = 0;
    int mismatched = 0;

    m_seg_scroll_reader #(
        .NDIGIT(NDIGIT), .SCROLL_DIV(SCROLL_DIV), .MUX_DIV(MUX_DIV), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .sel(sel), .rom_sw(rom_sw), .rom_adr(rom_adr),
        .rom_dat(rom_dat), .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    assign rom_dat = rom_tbl[{rom_sw, rom_adr}];

    // Reference model: message position, glyph buffer, run-cycle count, pending step latency, display cycle.
    logic              m_sw;
    logic [3:0]        m_adr;
    logic [7:0]        m_buf [NDIGIT];
    logic [7:0]        m_seg;
    logic [NDIGIT-1:0] m_an;
    int m_cnt, m_pend, m_cyc, m_d;
    int m_loads = 0;

    task automatic model_reset();
        m_sw = 1'b0; m_adr = 4'h0; m_cnt = 0; m_pend = 0; m_cyc = 0;
        m_seg = 8'hFF; m_an = '1;
        for (int i = 0; i < NDIGIT; i++) m_buf[i] = 8'hFF;
    endtask

    task automatic model_step();
        m_d   = (m_cyc / MUX_DIV) % NDIGIT;
        m_seg = m_buf[m_d];
        m_an  = ~(NDIGIT'(1) << m_d);
`ifdef MUX_BLANK_EN
        if (m_cyc % MUX_DIV < BLANK_CYC) begin
            m_seg = 8'hFF;
            m_an  = '1;
        end
`endif
        m_cyc++;
        if (sel != m_sw) begin
            m_sw = sel; m_adr = 4'h0; m_cnt = 0; m_pend = 0;
            for (int i = 0; i < NDIGIT; i++) m_buf[i] = 8'hFF;
        end else begin
            if (m_pend == 1) begin
                for (int i = NDIGIT - 1; i > 0; i--) m_buf[i] = m_buf[i-1];
                m_buf[0] = rom_tbl[{m_sw, m_adr}];
                m_adr = m_adr + 4'h1;
                m_loads++;
                m_pend = 0;
            end else if (m_pend == 2) m_pend = 1;
            if (!run) m_cnt = 0;
            else if (m_cnt == SCROLL_DIV - 1) begin
                m_cnt  = 0;
                m_pend = 2;
            end else m_cnt++;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    function automatic logic fd_exp();
        return m_pend == 1 && m_adr == 4'hf && sel == m_sw;
    endfunction

    task automatic test_reset();
        logic [3:0] an_seen = 4'h0;
        run = 1'b0; sel = 1'b0;
        #3 rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if ({rom_adr, seg, an, frame_done, rom_sw} !== {4'h0, 8'hFF, 4'hF, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got adr=%h seg=%h an=%h fd=%b sw=%b want 0 ff f 0 0", rom_adr, seg, an, frame_done, rom_sw);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            compared++;
            if ({rom_adr, seg, an, frame_done, rom_sw} !== {m_adr, m_seg, m_an, fd_exp(), m_sw}) begin
                mismatched++;
                $display("FAIL reset_idle cyc=%0d: got adr=%h seg=%h an=%h fd=%b want adr=%h seg=%h an=%h fd=%b",
                         i, rom_adr, seg, an, frame_done, m_adr, m_seg, m_an, fd_exp());
            end
            compared++;
            if (rom_adr !== 4'h0 || frame_done !== 1'b0 || seg !== 8'hFF) begin
                mismatched++;
                $display("FAIL reset_quiet cyc=%0d: got adr=%h fd=%b seg=%h want 0 0 ff", i, rom_adr, frame_done, seg);
            end
            for (int k = 0; k < 4; k++) if (an == ~(4'(1) << k)) an_seen[k] = 1'b1;
        end
        compared++;
        if (an_seen !== 4'hF) begin
            mismatched++;
            $display("FAIL reset_an_cycle: digits seen=%b want 1111", an_seen);
        end
    endtask

    task automatic test_hello();
        int n = 0;
        run = 1'b1;
        while (m_adr != 4'h4 && n < 100) begin
            @(negedge clk);
            n++;
            compared++;
            if ({rom_adr, seg, an, frame_done, rom_sw} !== {m_adr, m_seg, m_an, fd_exp(), m_sw}) begin
                mismatched++;
                $display("FAIL hello_run: got adr=%h seg=%h an=%h fd=%b want adr=%h seg=%h an=%h fd=%b",
                         rom_adr, seg, an, frame_done, m_adr, m_seg, m_an, fd_exp());
            end
        end
        run = 1'b0;
        compared++;
        if (n >= 100) begin
            mismatched++;
            $display("FAIL hello_timeout: got adr=%h want 4 within 100 cycles", rom_adr);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            compared++;
            if ({rom_adr, seg, an} !== {4'h4, m_seg, m_an}) begin
                mismatched++;
                $display("FAIL hello_hold: got adr=%h seg=%h an=%h want adr=4 seg=%h an=%h", rom_adr, seg, an, m_seg, m_an);
            end
            if (i > 0 && an == 4'hE) begin
                compared++;
                if (seg !== 8'hC7) begin
                    mismatched++;
                    $display("FAIL hello_digit0: got seg=%h want c7", seg);
                end
            end
            if (i > 0 && an == 4'h7) begin
                compared++;
                if (seg !== 8'h89) begin
                    mismatched++;
                    $display("FAIL hello_digit3: got seg=%h want 89", seg);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int target = m_loads + 16;
        int pulses = 0;
        int n = 0;
        run = 1'b1;
        while (m_loads < target && n < 200) begin
            @(negedge clk);
            n++;
            if (frame_done === 1'b1) pulses++;
            compared++;
            if ({rom_adr, seg, an, frame_done} !== {m_adr, m_seg, m_an, fd_exp()}) begin
                mismatched++;
                $display("FAIL wrap_run: got adr=%h seg=%h an=%h fd=%b want adr=%h seg=%h an=%h fd=%b",
                         rom_adr, seg, an, frame_done, m_adr, m_seg, m_an, fd_exp());
            end
        end
        run = 1'b0;
        compared++;
        if (pulses != 1 || rom_adr !== 4'h4 || n >= 200) begin
            mismatched++;
            $display("FAIL wrap_frame: got pulses=%0d adr=%h cycles=%0d want pulses=1 adr=4", pulses, rom_adr, n);
        end
    endtask

    task automatic test_sel();
        int n = 0;
        int extra = $urandom_range(0, 5);
        run = 1'b1;
        while (m_adr != 4'h5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (extra) @(negedge clk);
        sel = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            compared++;
            if ({rom_adr, seg, an, frame_done, rom_sw} !== {m_adr, m_seg, m_an, fd_exp(), m_sw}) begin
                mismatched++;
                $display("FAIL sel_model cyc=%0d: got adr=%h seg=%h an=%h sw=%b want adr=%h seg=%h an=%h sw=%b",
                         i, rom_adr, seg, an, rom_sw, m_adr, m_seg, m_an, m_sw);
            end
            if (i == 1) begin
                compared++;
                if ({rom_adr, rom_sw, frame_done} !== {4'h0, 1'b1, 1'b0}) begin
                    mismatched++;
                    $display("FAIL sel_restart: got adr=%h sw=%b fd=%b want 0 1 0", rom_adr, rom_sw, frame_done);
                end
            end else begin
                compared++;
                if (seg !== 8'hFF) begin
                    mismatched++;
                    $display("FAIL sel_blank cyc=%0d: got seg=%h want ff", i, seg);
                end
            end
        end
        n = 0;
        while (m_adr != 4'h1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0 && an == 4'hE) begin
                compared++;
                if (seg !== 8'hC2) begin
                    mismatched++;
                    $display("FAIL sel_first_glyph: got seg=%h want c2", seg);
                end
            end
        end
    endtask

    task automatic test_run_drop();
        logic [3:0] a0;
        int n = 0;
        run = 1'b1;
        while (m_pend != 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        a0  = m_adr;
        run = 1'b0;
        compared++;
        if (n >= 20 || rom_adr !== a0) begin
            mismatched++;
            $display("FAIL drop_fetch: got adr=%h cycles=%0d want adr=%h", rom_adr, n, a0);
        end
        repeat (2) @(negedge clk);
        compared++;
        if (rom_adr !== a0 + 4'h1) begin
            mismatched++;
            $display("FAIL drop_load: got adr=%h want %h", rom_adr, a0 + 4'h1);
        end
        for (int i = 0; i < 3 * SCROLL_DIV + 2; i++) begin
            @(negedge clk);
            compared++;
            if ({rom_adr, frame_done, seg, an} !== {a0 + 4'h1, 1'b0, m_seg, m_an}) begin
                mismatched++;
                $display("FAIL drop_frozen cyc=%0d: got adr=%h fd=%b seg=%h an=%h want adr=%h fd=0 seg=%h an=%h",
                         i, rom_adr, frame_done, seg, an, a0 + 4'h1, m_seg, m_an);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            compared++;
            if ({rom_adr, seg, an, frame_done, rom_sw} !== {m_adr, m_seg, m_an, fd_exp(), m_sw}) begin
                mismatched++;
                $display("FAIL random cyc=%0d: got adr=%h seg=%h an=%h fd=%b sw=%b want adr=%h seg=%h an=%h fd=%b sw=%b",
                         i, rom_adr, seg, an, frame_done, rom_sw, m_adr, m_seg, m_an, fd_exp(), m_sw);
            end
            run = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 39) == 0) sel = ~sel;
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        sel = 1'b0;
        run = 1'b1;
        repeat (2) @(negedge clk);
        while (m_pend != 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({rom_adr, seg, an, frame_done, rom_sw} !== {4'h0, 8'hFF, 4'hF, 1'b0, 1'b0} || n >= 20) begin
            mismatched++;
            $display("FAIL async_reset: got adr=%h seg=%h an=%h fd=%b sw=%b want 0 ff f 0 0", rom_adr, seg, an, frame_done, rom_sw);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            compared++;
            if ({rom_adr, seg, an, frame_done, rom_sw} !== {m_adr, m_seg, m_an, fd_exp(), m_sw}) begin
                mismatched++;
                $display("FAIL async_restart cyc=%0d: got adr=%h seg=%h an=%h fd=%b want adr=%h seg=%h an=%h fd=%b",
                         k, rom_adr, seg, an, frame_done, m_adr, m_seg, m_an, fd_exp());
            end
`ifdef MUX_BLANK_EN
            if (k % 2 == 1) begin
                compared++;
                if (an !== 4'hF) begin
                    mismatched++;
                    $display("FAIL async_blank cyc=%0d: got an=%h want f", k, an);
                end
            end
`endif
        end
        run = 1'b0;
    endtask

    initial begin
        rom_tbl = '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF, 8'h92, 8'h86,
                    8'h86, 8'hFF, 8'hC6, 8'hC0, 8'hC1, 8'hFF, 8'h88, 8'hA1,
                    8'hC2, 8'hC0, 8'hC0, 8'hA1, 8'hFF, 8'hA3, 8'hAB, 8'h86,
                    8'hFF, 8'hE1, 8'hC1, 8'h88, 8'h92, 8'hFF, 8'h91, 8'hF7};
        test_reset();
        test_hello();
        test_wrap();
        test_sel();
        test_run_drop();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
